stoch_window_decoder: RTL and testbench

- Downstream consumer of the stochastic bitstream generator.
- Takes the signed-unipolar pair in_p/in_m and integrates the bitstream over a fixed window of 2^WINDOW_LOG2 samples.
- Emits a signed count estimate (value × 2^WINDOW_LOG2) through a valid/ready output register.
- Used to decode stochastic results back to binary, for checking and for handoff to fixed-point logic.

---
 rtl/stoch_window_decoder_if.sv | 26 ++
 rtl/stoch_window_decoder.sv | 99 +++++++++
 tb/tb_stoch_window_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/stoch_window_decoder_if.sv
// Sample/result bundle between a stochastic bitstream source, the window decoder and its consumer.
// The master modport drives samples and ready; the slave modport is the decoder side.
interface stoch_window_decoder_if #(
  parameter int WINDOW_LOG2 = 10
);
  localparam int CNT_WIDTH = WINDOW_LOG2 + 2;

  logic                 en;
  logic                 in_p;
  logic                 in_m;
  logic [CNT_WIDTH-1:0] out_value;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overrun;
  logic                 busy;

  modport master (
    output en, in_p, in_m, out_ready,
    input  out_value, out_valid, overrun, busy
  );

  modport slave (
    input  en, in_p, in_m, out_ready,
    output out_value, out_valid, overrun, busy
  );
endinterface

// File: rtl/stoch_window_decoder.sv
// Integrates in_p - in_m over 2^WINDOW_LOG2 accepted samples; result registered one cycle after the last sample.
// The result is held until out_ready; a new window landing on an unconsumed result overwrites it and sets sticky overrun.
module stoch_window_decoder #(
  parameter int WINDOW_LOG2 = 10
) (
  input  logic                CLK,
  input  logic                RST,
  stoch_window_decoder_if.slave bus
);
  localparam int CNT_WIDTH = WINDOW_LOG2 + 2;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                        state_q, state_d;
  logic signed [CNT_WIDTH-1:0]   acc_q, acc_d;
  logic [WINDOW_LOG2-1:0]        cnt_q, cnt_d;
  logic signed [CNT_WIDTH-1:0]   value_q, value_d;
  logic                          valid_q, valid_d;
  logic                          overrun_q, overrun_d;

  logic                          accept;
  logic                          complete;
  logic signed [CNT_WIDTH-1:0]   delta;
  logic signed [CNT_WIDTH-1:0]   sum;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    value_d   = value_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    accept    = 1'b0;
    complete  = 1'b0;

    // Both polarities set (or both clear) cancel out.
    delta = '0;
    if (bus.in_p && !bus.in_m) begin
      delta = CNT_WIDTH'(1);
    end else if (!bus.in_p && bus.in_m) begin
      delta = '1;
    end
    sum = acc_q + delta;

    case (state_q)
      IDLE: begin
        if (bus.en) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        accept = bus.en;
      end
      default: state_d = IDLE;
    endcase

    complete = accept && (cnt_q == '1);

    if (accept) begin
      cnt_d = cnt_q + 1'b1;
      acc_d = complete ? '0 : sum;
    end

    // A completion always wins over the handshake so the fresh result is never dropped.
    if (complete) begin
      value_d = sum;
      valid_d = 1'b1;
      if (valid_q && !bus.out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.out_value = value_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_stoch_window_decoder.sv
// Directed test-plan scenarios plus randomized traffic, all checked against a sample-list reference model.
module tb_stoch_window_decoder;
  localparam int WL2 = 4;
  localparam int N   = 1 << WL2;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: samples of the open window, last result, flags.
  int   win_q[$];
  int   m_value = 0;
  bit   m_valid = 1'b0;
  bit   m_overrun = 1'b0;

  stoch_window_decoder_if #(.WINDOW_LOG2(WL2)) bus ();

  stoch_window_decoder #(.WINDOW_LOG2(WL2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int window_sum();
    int s = 0;
    foreach (win_q[i]) s += win_q[i];
    return s;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit p, input bit m, input bit rdy);
    bit done = 1'b0;
    if (r) begin
      win_q.delete();
      m_value = 0;
      m_valid = 1'b0;
      m_overrun = 1'b0;
      return;
    end
    if (e) begin
      win_q.push_back(int'(p) - int'(m));
      if (win_q.size() == N) begin
        done = 1'b1;
        if (m_valid && !rdy) m_overrun = 1'b1;
        m_value = window_sum();
        m_valid = 1'b1;
        win_q.delete();
      end
    end
    if (!done && m_valid && rdy) m_valid = 1'b0;
  endtask

  task automatic compare_all();
    chk("out_valid", int'(bus.out_valid), int'(m_valid));
    chk("out_value", int'($signed(bus.out_value)), m_value);
    chk("overrun", int'(bus.overrun), int'(m_overrun));
    chk("busy", int'(bus.busy), int'(win_q.size() != 0));
  endtask

  // Inputs are changed 1 time unit after the rising edge and outputs sampled at the same point.
  task automatic step(input bit r, input bit e, input bit p, input bit m, input bit rdy);
    RST           = r;
    bus.en        = e;
    bus.in_p      = p;
    bus.in_m      = m;
    bus.out_ready = rdy;
    @(posedge CLK);
    model_edge(r, e, p, m, rdy);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic run(input int cnt, input bit p, input bit m, input bit rdy);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b1, p, m, rdy);
  endtask

  initial begin
    RST = 1'b1;
    bus.en = 1'b0;
    bus.in_p = 1'b0;
    bus.in_m = 1'b0;
    bus.out_ready = 1'b0;

    do_reset();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_value", int'($signed(bus.out_value)), 0);
    chk("rst_busy", int'(bus.busy), 0);

    // All +1, then all -1, then both set.
    run(N - 1, 1'b1, 1'b0, 1'b1);
    chk("plus_pending", int'(bus.out_valid), 0);
    run(1, 1'b1, 1'b0, 1'b1);
    chk("plus16_valid", int'(bus.out_valid), 1);
    chk("plus16_value", int'($signed(bus.out_value)), 16);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("plus16_clear", int'(bus.out_valid), 0);
    run(N, 1'b0, 1'b1, 1'b1);
    chk("minus16_value", int'($signed(bus.out_value)), -16);
    chk("minus16_bits", int'(bus.out_value), 6'b110000);
    run(N, 1'b1, 1'b1, 1'b1);
    chk("both_value", int'($signed(bus.out_value)), 0);
    chk("both_valid", int'(bus.out_valid), 1);

    // Alternating +1/0 with a 5-cycle pause mid-window.
    for (int i = 0; i < N + 5; i++) begin
      if (i >= 7 && i < 12) begin
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("pause_busy", int'(bus.busy), 1);
      end else begin
        step(1'b0, 1'b1, ((i < 7 ? i : i - 5) % 2) == 0, 1'b0, 1'b1);
      end
    end
    chk("alt_value", int'($signed(bus.out_value)), 8);
    chk("alt_valid", int'(bus.out_valid), 1);

    // Two windows without a consumer: overrun.
    do_reset();
    run(N, 1'b1, 1'b0, 1'b0);
    run(N, 1'b0, 1'b1, 1'b0);
    chk("ovr_value", int'($signed(bus.out_value)), -16);
    chk("ovr_valid", int'(bus.out_valid), 1);
    chk("ovr_flag", int'(bus.overrun), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_drain", int'(bus.out_valid), 0);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // Ready arrives exactly on the second completion.
    do_reset();
    run(N, 1'b1, 1'b0, 1'b0);
    run(N - 1, 1'b0, 1'b1, 1'b0);
    run(1, 1'b0, 1'b1, 1'b1);
    chk("race_valid", int'(bus.out_valid), 1);
    chk("race_value", int'($signed(bus.out_value)), -16);
    chk("race_ovr", int'(bus.overrun), 0);

    // Reset mid-window discards the partial sum.
    do_reset();
    run(9, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("midrst_valid", int'(bus.out_valid), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    run(N, 1'b1, 1'b0, 1'b0);
    chk("midrst_value", int'($signed(bus.out_value)), 16);
    chk("midrst_ovr", int'(bus.overrun), 0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
